// File: rtl/tc_multi_port_ram.sv
// Multi-port RAM: one byte-masked write port, NUM_READ registered read ports,
// same-cycle write forwarding to readers, and a sequential clear engine that
// zeroes the whole array after reset or on request.
module tc_multi_port_ram #(
  parameter int unsigned BIT_WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MEM_WORDS      = 65536,
  parameter int unsigned NUM_READ       = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [NUM_READ-1:0]            load,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] address_r,
  input  logic                           save,
  input  logic [ADDR_WIDTH-1:0]          address_w,
  input  logic [BIT_WIDTH-1:0]           in,
  input  logic [BIT_WIDTH/8-1:0]         mask,
  output logic [NUM_READ*BIT_WIDTH-1:0]  out,
  output logic [NUM_READ-1:0]            out_valid,
  output logic                           busy
);

  localparam int                    NumBytes  = BIT_WIDTH / 8;
  localparam int unsigned           IdxW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // One extra bit so MEM_WORDS == 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   MemWordsW = (ADDR_WIDTH + 1)'(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(MEM_WORDS - 1);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [BIT_WIDTH-1:0]   mem [MEM_WORDS];
  logic                   w_in_range;
  logic                   wr_en;

  assign busy       = (state_q == StClear);
  assign w_in_range = ({1'b0, address_w} < MemWordsW);
  assign wr_en      = save && !busy && w_in_range;

  function automatic logic [BIT_WIDTH-1:0] merge_bytes(input logic [BIT_WIDTH-1:0] old_word,
                                                       input logic [BIT_WIDTH-1:0] new_word,
                                                       input logic [NumBytes-1:0]  byte_en);
    logic [BIT_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NumBytes; b++) begin
      if (byte_en[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  // Clear engine next state: walk ptr over every word, then return to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        if (ptr_q == LastAddr) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  // Clear engine state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ResetState;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array update: clear engine has priority; user writes are blocked while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr_q[IdxW-1:0]] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (mask[b]) mem[address_w[IdxW-1:0]][b*8 +: 8] <= in[b*8 +: 8];
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  in_range;
    logic [BIT_WIDTH-1:0]  rd_data;
    logic [BIT_WIDTH-1:0]  data_q;
    logic                  valid_q;

    assign addr     = address_r[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_range = ({1'b0, addr} < MemWordsW);

    // Read word, forwarding a same-cycle write to the same address byte by byte.
    always_comb begin
      rd_data = '0;
      if (in_range) begin
        rd_data = mem[addr[IdxW-1:0]];
        if (wr_en && (addr == address_w)) rd_data = merge_bytes(rd_data, in, mask);
      end
    end

    // Registered read output; idle or busy ports present zero data, not valid.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (load[k] && !busy) begin
        data_q  <= rd_data;
        valid_q <= 1'b1;
      end else begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end
    end

    assign out[k*BIT_WIDTH +: BIT_WIDTH] = data_q;
    assign out_valid[k]                  = valid_q;
  end

endmodule
